frame_input_sampler: RTL and testbench



---
 rtl/frame_input_sampler.sv | 155 +++++++++++++++
 tb/tb_frame_input_sampler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_input_sampler.sv
// frame_input_sampler: samples debounced buttons once per frame (vsync falling edge)
// and issues single-frame move/chop commands with hold-to-repeat. Optional macro: CHOP_HOLD_EN.
module frame_input_sampler #(
   parameter int unsigned REPEAT_DELAY = 15,
   parameter int unsigned REPEAT_RATE  = 4
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       vsync_in,
   input  logic       pause_in,
   input  logic       left_in,
   input  logic       right_in,
   input  logic       up_in,
   input  logic       down_in,
   input  logic       chop_in,
   output logic       frame_tick_out,
   output logic       move_valid_out,
   output logic [1:0] move_dir_out,
   output logic       chop_out,
   output logic       held_dir_out
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DELAY  = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   localparam logic [7:0] DELAY_LD = 8'(REPEAT_DELAY);
   localparam logic [7:0] RATE_LD  = 8'(REPEAT_RATE);

   logic       vs_q;
   logic       frame_edge;
   logic [1:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] cur_q, cur_d;
   logic       chop_prev_q, chop_prev_d;
   logic       tick_q, tick_d;
   logic       move_valid_q, move_valid_d;
   logic [1:0] move_dir_q, move_dir_d;
   logic       chop_q, chop_d;
   logic       held_q, held_d;
   logic       sel_valid;
   logic [1:0] sel_dir;
   logic       issue;

   assign frame_edge = vs_q & ~vsync_in;

   // Later assignments override earlier ones, giving up > down > left > right.
   always_comb begin
      sel_valid = up_in | down_in | left_in | right_in;
      sel_dir   = DIR_RIGHT;
      if (left_in) sel_dir = DIR_LEFT;
      if (down_in) sel_dir = DIR_DOWN;
      if (up_in)   sel_dir = DIR_UP;
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cur_d        = cur_q;
      chop_prev_d  = chop_prev_q;
      tick_d       = frame_edge;
      move_valid_d = 1'b0;
      move_dir_d   = move_dir_q;
      chop_d       = 1'b0;
      held_d       = held_q;
      issue        = 1'b0;
      if (frame_edge) begin
         chop_prev_d = chop_in;
         held_d      = sel_valid;
         if (pause_in) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else begin
`ifdef CHOP_HOLD_EN
            chop_d = chop_in;
`else
            chop_d = chop_in & ~chop_prev_q;
`endif
            case (state_q)
               ST_IDLE: begin
                  if (sel_valid) begin
                     issue   = 1'b1;
                     cnt_d   = DELAY_LD;
                     state_d = ST_DELAY;
                  end
               end
               ST_DELAY, ST_REPEAT: begin
                  if (!sel_valid) begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                  end else if (sel_dir != cur_q) begin
                     issue   = 1'b1;
                     cnt_d   = DELAY_LD;
                     state_d = ST_DELAY;
                  end else if (cnt_q <= 8'd1) begin
                     // Decrement would reach 0: fire and reload instead of wrapping.
                     issue   = 1'b1;
                     cnt_d   = RATE_LD;
                     state_d = ST_REPEAT;
                  end else begin
                     cnt_d = cnt_q - 8'd1;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            endcase
            if (issue) begin
               cur_d        = sel_dir;
               move_dir_d   = sel_dir;
               move_valid_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         vs_q         <= 1'b0;
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         cur_q        <= '0;
         chop_prev_q  <= 1'b0;
         tick_q       <= 1'b0;
         move_valid_q <= 1'b0;
         move_dir_q   <= '0;
         chop_q       <= 1'b0;
         held_q       <= 1'b0;
      end else begin
         vs_q         <= vsync_in;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cur_q        <= cur_d;
         chop_prev_q  <= chop_prev_d;
         tick_q       <= tick_d;
         move_valid_q <= move_valid_d;
         move_dir_q   <= move_dir_d;
         chop_q       <= chop_d;
         held_q       <= held_d;
      end
   end

   assign frame_tick_out = tick_q;
   assign move_valid_out = move_valid_q;
   assign move_dir_out   = move_dir_q;
   assign chop_out       = chop_q;
   assign held_dir_out   = held_q;

endmodule

// File: tb/tb_frame_input_sampler.sv
// Self-checking bench for frame_input_sampler: frame-level reference model plus directed
// and randomized scenarios.
module tb_frame_input_sampler;

   localparam int D = 15;
   localparam int R = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       vsync = 1'b0, pause = 1'b0;
   logic       left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0, chop = 1'b0;
   logic       tick_o, mv_o, chop_o, held_o;
   logic [1:0] dir_o;

   int checks = 0;
   int passes = 0;

   frame_input_sampler #(.REPEAT_DELAY(D), .REPEAT_RATE(R)) dut (
      .clk_in(clk), .rst_in(rst_n), .vsync_in(vsync), .pause_in(pause),
      .left_in(left), .right_in(right), .up_in(up), .down_in(down), .chop_in(chop),
      .frame_tick_out(tick_o), .move_valid_out(mv_o), .move_dir_out(dir_o),
      .chop_out(chop_o), .held_dir_out(held_o)
   );

   always #20 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Reference model: k counts frames a direction has been continuously selected.
   logic       m_vs, m_chop_prev;
   int         m_run;
   logic [1:0] m_dir;
   logic       exp_tick, exp_mv, exp_chop, exp_held;
   logic [1:0] exp_dir;

   always @(posedge clk or negedge rst_n) begin : model
      int k;
      logic [1:0] d;
      logic any;
      logic fire;
      if (!rst_n) begin
         m_vs <= 1'b0; m_chop_prev <= 1'b0; m_run <= -1; m_dir <= 2'd0;
         exp_tick <= 1'b0; exp_mv <= 1'b0; exp_chop <= 1'b0; exp_held <= 1'b0; exp_dir <= 2'd0;
      end else begin
         m_vs     <= vsync;
         exp_tick <= m_vs && !vsync;
         exp_mv   <= 1'b0;
         exp_chop <= 1'b0;
         if (m_vs && !vsync) begin
            any = up | down | left | right;
            d = up ? 2'd0 : down ? 2'd1 : left ? 2'd2 : 2'd3;
            m_chop_prev <= chop;
            exp_held    <= any;
            if (pause || !any) begin
               m_run <= -1;
            end else begin
               k = (m_run >= 0 && d == m_dir) ? m_run + 1 : 0;
               fire = (k == 0) || (k == D) || (k > D && ((k - D) % R) == 0);
               m_run <= k;
               m_dir <= d;
               if (fire) begin
                  exp_mv  <= 1'b1;
                  exp_dir <= d;
               end
            end
`ifdef CHOP_HOLD_EN
            exp_chop <= !pause && chop;
`else
            exp_chop <= !pause && chop && !m_chop_prev;
`endif
         end
      end
   end

   always @(negedge clk) begin
      check("cyc_tick", int'(tick_o), int'(exp_tick));
      check("cyc_move_valid", int'(mv_o), int'(exp_mv));
      check("cyc_move_dir", int'(dir_o), int'(exp_dir));
      check("cyc_chop", int'(chop_o), int'(exp_chop));
      check("cyc_held", int'(held_o), int'(exp_held));
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Starts and ends on a negedge; returns inside the frame_tick cycle.
   task automatic frame();
      repeat (3) @(negedge clk);
      vsync = 1'b1;
      repeat (3) @(negedge clk);
      vsync = 1'b0;
      @(negedge clk);
   endtask

   function automatic bit up_move_frame(input int f);
      return f == 0 || f == 15 || f == 19 || f == 23 || f == 27;
   endfunction

   initial begin
      int n;
      logic [3:0] btn;
      logic [3:0] saved;

      // Reset, idle buttons.
      repeat (3) @(negedge clk);
      check("rst_tick", int'(tick_o), 0);
      check("rst_mv", int'(mv_o), 0);
      check("rst_dir", int'(dir_o), 0);
      check("rst_chop", int'(chop_o), 0);
      rst_n = 1'b1;
      n = 0;
      for (int f = 0; f < 3; f++) begin
         frame();
         if (tick_o) n++;
         check("idle_mv", int'(mv_o), 0);
         check("idle_chop", int'(chop_o), 0);
      end
      check("idle_tick_count", n, 3);

      // up held 30 frames.
      up = 1'b1;
      for (int f = 0; f < 30; f++) begin
         frame();
         check("up_mv", int'(mv_o), int'(up_move_frame(f)));
         check("up_model_pin", int'(exp_mv), int'(up_move_frame(f)));
         if (up_move_frame(f)) check("up_dir", int'(dir_o), 0);
      end
      up = 1'b0;
      frame();

      // down+left, then release down.
      left = 1'b1; down = 1'b1;
      frame();
      check("dl_mv", int'(mv_o), 1);
      check("dl_dir", int'(dir_o), 1);
      down = 1'b0;
      for (int j = 0; j <= 15; j++) begin
         frame();
         check("left_mv", int'(mv_o), int'(j == 0 || j == 15));
         if (j == 0 || j == 15) check("left_dir", int'(dir_o), 2);
      end
      left = 1'b0;
      frame();

      // chop held 10 frames.
      chop = 1'b1;
      n = 0;
      for (int f = 0; f < 10; f++) begin
         frame();
         if (chop_o) n++;
      end
`ifdef CHOP_HOLD_EN
      check("chop_count", n, 10);
`else
      check("chop_count", n, 1);
`endif
      chop = 1'b0;
      frame();

      // Pause with right and chop held.
      pause = 1'b1; right = 1'b1; chop = 1'b1;
      for (int f = 0; f < 5; f++) begin
         frame();
         check("pause_tick", int'(tick_o), 1);
         check("pause_mv", int'(mv_o), 0);
         check("pause_chop", int'(chop_o), 0);
      end
      pause = 1'b0;
      frame();
      check("unpause_mv", int'(mv_o), 1);
      check("unpause_dir", int'(dir_o), 3);
`ifdef CHOP_HOLD_EN
      check("unpause_chop", int'(chop_o), 1);
`else
      check("unpause_chop", int'(chop_o), 0);
`endif
      right = 1'b0; chop = 1'b0;
      frame();

      // right pulsed only between edges.
      @(negedge clk);
      right = 1'b1;
      repeat (2) @(negedge clk);
      right = 1'b0;
      frame();
      check("glitch_mv", int'(mv_o), 0);

      // Reset mid-REPEAT on a move tick, then release with right still held.
      right = 1'b1;
      for (int f = 0; f < 20; f++) frame();
      check("rep_mv_before_rst", int'(mv_o), 1);
      #5 rst_n = 1'b0;
      #1;
      check("arst_tick", int'(tick_o), 0);
      check("arst_mv", int'(mv_o), 0);
      check("arst_dir", int'(dir_o), 0);
      check("arst_held", int'(held_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      frame();
      check("post_rst_mv", int'(mv_o), 1);
      check("post_rst_dir", int'(dir_o), 3);
      right = 1'b0;
      frame();

      // Randomized frames with sticky buttons, occasional pause and mid-frame noise.
      btn = 4'b0;
      for (int f = 0; f < 300; f++) begin
         if ($urandom_range(0, 5) == 0) btn = 4'($urandom);
         {up, down, left, right} = btn;
         pause = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 2) == 0) chop = ~chop;
         if ($urandom_range(0, 3) == 0) begin
            saved = {up, down, left, right};
            {up, down, left, right} = 4'($urandom);
            @(negedge clk);
            {up, down, left, right} = saved;
         end
         frame();
      end
      {up, down, left, right} = 4'b0;
      pause = 1'b0; chop = 1'b0;
      frame();
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
